sram_emulator: RTL and testbench
================================

Name: sram_emulator

Overview:
- Responder end of the 16-bit asynchronous SRAM bus (DE2-style 256K x 16 pinout) driven by SRAM_Controller.
- Emulates the external chip with on-chip byte-enabled RAM and a programmable read access latency.
- Used in simulation and in FPGA builds without the board SRAM; it sits on the SRAM_* nets in place of the device.
- Exposes read/write activity counters for verification.

Parameters:
- MEM_DEPTH_LOG2, 12, number of implemented word-address bits; upper SRAM_ADDR bits are ignored, so addresses alias modulo 2^MEM_DEPTH_LOG2.
- READ_LATENCY, 2, clocks from the start of a read to DQ being driven; legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- SRAM_DQ  inout  `SRAM_DATA_BUS (16)  data bus; driven only in READ_DRIVE, otherwise high-Z.
- SRAM_ADDR  in  `SRAM_ADDRESS_BUS (18)  word address.
- SRAM_UB_N  in  1  active-low upper-byte (DQ[15:8]) enable.
- SRAM_LB_N  in  1  active-low lower-byte (DQ[7:0]) enable.
- SRAM_WE_N  in  1  active-low write enable.
- SRAM_CE_N  in  1  active-low chip enable.
- SRAM_OE_N  in  1  active-low output enable.
- read_valid  out  1  high while DQ is driven with read data.
- rd_count  out  16  completed reads, wraps at 0xFFFF.
- wr_count  out  16  write cycles committed, wraps at 0xFFFF.

Behaviour:
- Reset (async, rst=1):
  - State IDLE, latency counter 0, latched address 0.
  - read_valid=0, rd_count=0, wr_count=0, SRAM_DQ=Z immediately.
  - Memory contents are not cleared.
- Decoded bus conditions, sampled at posedge clk:
  - sel: CE_N=0.
  - wr: sel & WE_N=0.
  - rd: sel & WE_N=1 & OE_N=0.
  - otherwise idle.
- States: IDLE, READ_WAIT, READ_DRIVE, WRITE.
- IDLE:
  - wr -> WRITE.
  - rd -> READ_WAIT; latch ADDR; counter=1.
  - else stay.
- WRITE:
  - Each clock with wr true commits mem[ADDR] lanes: DQ[15:8] if UB_N=0, DQ[7:0] if LB_N=0.
  - wr_count increments by 1 per committing clock, including when both lanes are masked.
  - Back-to-back writes to different addresses commit every clock.
  - Exit: rd -> READ_WAIT (latch ADDR, counter=1); else -> IDLE.
- READ_WAIT:
  - counter increments each clock while rd holds and ADDR equals the latched address.
  - When counter reaches READ_LATENCY -> READ_DRIVE. Data is driven READ_LATENCY clocks after the clock that accepted the read.
  - ADDR change with rd still true: relatch ADDR, counter=1, stay.
  - wr -> WRITE (commits that clock).
  - rd false -> IDLE.
- READ_DRIVE:
  - DQ = mem[latched addr], with byte lanes whose _N is high driven as 0x00; read_valid=1.
  - rd_count increments once, on entry.
  - Stays while rd holds and ADDR is unchanged.
  - ADDR change -> READ_WAIT (relatch, counter=1).
  - wr -> WRITE.
  - rd false -> IDLE.
- Bus release:
  - DQ output enable = (state==READ_DRIVE) & ~CE_N & ~OE_N & WE_N, evaluated combinationally. Raising OE_N/CE_N or lowering WE_N releases DQ in the same cycle, with no bus contention with a controller write.
  - read_valid uses the same expression.
- Simultaneous events:
  - WE_N low overrides OE_N low; write takes priority.
  - Write and read of the same address in consecutive clocks: the read returns the new data.
- Aliasing: address bits at and above MEM_DEPTH_LOG2 are ignored for both storage and change detection.
- Reset mid-read: DQ released asynchronously; the next read restarts the full latency.

Decomposition:
- Defines.v: reuse `SRAM_DATA_BUS and `SRAM_ADDRESS_BUS; add `SRAM_EMU_READ_LATENCY (2) and the state encodings (2-bit).
- Sub-module sram_emulator_mem: single-port, byte-enabled, synchronous-write, asynchronous-read RAM of 2^MEM_DEPTH_LOG2 x 16. The top holds the FSM, counters and tristate driver.

Test Plan:
- Write 0xBEEF to addr 0x00010 (UB_N=LB_N=0, 1 clock), then read with OE_N=0 -> DQ=Z for the first 2 clocks, then DQ=0xBEEF with read_valid=1; wr_count=1, rd_count=1.
- Byte-masked write: 0x1234 full, then 0xAB00 with LB_N=1 -> read returns 0xAB34; read with UB_N=1 returns 0x0034.
- Address change mid-read: read 0x00010 then switch to 0x00011 at the latency-1 clock -> DQ stays Z, and the latency restarts with data of 0x00011 after 2 more clocks; rd_count increments by 1 only.
- WE_N pulled low while in READ_DRIVE -> DQ=Z in the same cycle, the write commits, and a subsequent read returns the written value.
- rst asserted mid-READ_WAIT and mid-READ_DRIVE -> DQ=Z and read_valid=0 asynchronously; counters 0; memory contents preserved on re-read.
- Aliasing with MEM_DEPTH_LOG2=12: write 0x5A5A to 0x01005, read 0x00005 -> 0x5A5A; writes to 0x0FFF then 0x1000 hit the two ends of the array (0x000 after wrap).

Source files
------------

// File: rtl/sram_emulator_pkg.sv
// Shared definitions for the SRAM emulator.
// Holds the bus widths of the DE2-style 256K x 16 async SRAM pinout, the
// default read latency, the 2-bit FSM state encoding, and small helpers for
// bus-condition decode and read-data byte-lane masking.
package sram_emulator_pkg;

    localparam int SRAM_DATA_BUS         = 16;
    localparam int SRAM_ADDRESS_BUS      = 18;
    localparam int SRAM_EMU_READ_LATENCY = 2;
    localparam int LAT_CNT_W             = 3;   // holds latencies up to 7

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_READ_DRIVE = 2'd2,
        ST_WRITE      = 2'd3
    } emu_state_t;

    typedef struct packed {
        logic wr;
        logic rd;
    } bus_cmd_t;

    // Write wins over read when WE_N and OE_N are both low.
    function automatic bus_cmd_t decode_bus(input logic ce_n,
                                            input logic we_n,
                                            input logic oe_n);
        bus_cmd_t cmd;
        logic     sel;
        sel    = ~ce_n;
        cmd.wr = sel & ~we_n;
        cmd.rd = sel & we_n & ~oe_n;
        return cmd;
    endfunction

    // Lanes whose active-low enable is high read back as 0x00.
    function automatic logic [SRAM_DATA_BUS-1:0] mask_lanes(
        input logic [SRAM_DATA_BUS-1:0] data,
        input logic                     ub_n,
        input logic                     lb_n);
        logic [SRAM_DATA_BUS-1:0] out;
        out[15:8] = ub_n ? 8'h00 : data[15:8];
        out[7:0]  = lb_n ? 8'h00 : data[7:0];
        return out;
    endfunction

endpackage

// File: rtl/sram_emulator_mem.sv
// Byte-enabled storage for the SRAM emulator.
// Single-port RAM of 2^ADDR_W x 16: synchronous write, asynchronous read on
// the same address port. Contents are never reset.
// Ports:
//   clk    - system clock
//   we     - write strobe, commits enabled lanes at posedge clk
//   be     - byte enables, be[1] = bits 15:8, be[0] = bits 7:0
//   addr   - word address (write and read)
//   wdata  - write data
//   rdata  - combinational read data at addr
module sram_emulator_mem
    import sram_emulator_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [1:0]               be,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [SRAM_DATA_BUS-1:0] wdata,
    output logic [SRAM_DATA_BUS-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [SRAM_DATA_BUS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_emulator.sv
// Responder side of the 16-bit asynchronous SRAM bus.
// Stands in for the external 256K x 16 device: accepts controller writes
// into on-chip byte-enabled RAM and returns read data after a programmable
// number of clocks. Read and write activity counters are exposed.
// Ports:
//   clk, rst    - system clock, async active-high reset
//   SRAM_DQ     - bidirectional data, driven only while returning read data
//   SRAM_ADDR   - word address (bits >= MEM_DEPTH_LOG2 ignored)
//   SRAM_UB_N   - upper byte enable (active low)
//   SRAM_LB_N   - lower byte enable (active low)
//   SRAM_WE_N   - write enable (active low)
//   SRAM_CE_N   - chip enable (active low)
//   SRAM_OE_N   - output enable (active low)
//   read_valid  - high while DQ carries read data
//   rd_count    - completed reads (wrapping)
//   wr_count    - committed write cycles (wrapping)
module sram_emulator
    import sram_emulator_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int READ_LATENCY   = SRAM_EMU_READ_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    inout  wire  [SRAM_DATA_BUS-1:0]    SRAM_DQ,
    input  logic [SRAM_ADDRESS_BUS-1:0] SRAM_ADDR,
    input  logic                        SRAM_UB_N,
    input  logic                        SRAM_LB_N,
    input  logic                        SRAM_WE_N,
    input  logic                        SRAM_CE_N,
    input  logic                        SRAM_OE_N,
    output logic                        read_valid,
    output logic [15:0]                 rd_count,
    output logic [15:0]                 wr_count
);

    // Out-of-range latencies are clamped into 1..7.
    localparam int LAT_EFF = (READ_LATENCY < 1) ? 1 :
                             (READ_LATENCY > 7) ? 7 : READ_LATENCY;
    localparam logic [LAT_CNT_W-1:0] LAT_TC = LAT_CNT_W'(LAT_EFF);

    emu_state_t                state;
    logic [LAT_CNT_W-1:0]      lat_cnt;
    logic [MEM_DEPTH_LOG2-1:0] addr_q;

    bus_cmd_t                  cmd;
    logic [MEM_DEPTH_LOG2-1:0] addr_lo;
    logic                      addr_chg;
    logic [MEM_DEPTH_LOG2-1:0] mem_addr;
    logic [SRAM_DATA_BUS-1:0]  mem_rdata;
    logic                      mem_we;
    logic                      dq_oe;
    logic                      unused_addr_hi;

    assign cmd      = decode_bus(SRAM_CE_N, SRAM_WE_N, SRAM_OE_N);
    assign addr_lo  = SRAM_ADDR[MEM_DEPTH_LOG2-1:0];
    assign addr_chg = (addr_lo != addr_q);
    assign unused_addr_hi = ^SRAM_ADDR[SRAM_ADDRESS_BUS-1:MEM_DEPTH_LOG2];

    // A write is committed on every clock the bus asks for one, whatever
    // state the FSM is in; the FSM only tracks where the bus is heading.
    assign mem_we   = cmd.wr & ~rst;
    // Single port: the bus address during writes, the latched read address
    // otherwise. A write followed by a read of the same word therefore sees
    // the freshly committed data.
    assign mem_addr = cmd.wr ? addr_lo : addr_q;

    sram_emulator_mem #(
        .ADDR_W (MEM_DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    ({~SRAM_UB_N, ~SRAM_LB_N}),
        .addr  (mem_addr),
        .wdata (SRAM_DQ),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            addr_q   <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (cmd.wr) wr_count <= wr_count + 16'd1;

            case (state)
                ST_IDLE: begin
                    if (cmd.wr) begin
                        state <= ST_WRITE;
                    end else if (cmd.rd) begin
                        state   <= ST_READ_WAIT;
                        addr_q  <= addr_lo;
                        lat_cnt <= LAT_CNT_W'(1);
                    end
                end

                ST_WRITE: begin
                    if (cmd.wr) begin
                        state <= ST_WRITE;
                    end else if (cmd.rd) begin
                        state   <= ST_READ_WAIT;
                        addr_q  <= addr_lo;
                        lat_cnt <= LAT_CNT_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_READ_WAIT: begin
                    if (cmd.wr) begin
                        state <= ST_WRITE;
                    end else if (cmd.rd) begin
                        if (addr_chg) begin
                            addr_q  <= addr_lo;
                            lat_cnt <= LAT_CNT_W'(1);
                        end else if (lat_cnt == LAT_TC) begin
                            state    <= ST_READ_DRIVE;
                            rd_count <= rd_count + 16'd1;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_CNT_W'(1);
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_READ_DRIVE: begin
                    if (cmd.wr) begin
                        state <= ST_WRITE;
                    end else if (cmd.rd) begin
                        if (addr_chg) begin
                            state   <= ST_READ_WAIT;
                            addr_q  <= addr_lo;
                            lat_cnt <= LAT_CNT_W'(1);
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus release is combinational so the controller can take DQ in the
    // same cycle it drops WE_N or raises OE_N/CE_N.
    assign dq_oe      = (state == ST_READ_DRIVE) & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
    assign read_valid = dq_oe;
    assign SRAM_DQ    = dq_oe ? mask_lanes(mem_rdata, SRAM_UB_N, SRAM_LB_N) : 'z;

endmodule

// File: tb/tb_sram_emulator.sv
module tb_sram_emulator;

    logic        clk;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic        read_valid;
    logic [15:0] rd_count, wr_count;
    logic [15:0] dq_drv;
    logic        dq_drv_en;

    int n_vec;
    int n_err;

    assign sram_dq = dq_drv_en ? dq_drv : 16'hzzzz;

    sram_emulator dut (
        .clk        (clk),
        .rst        (rst),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .SRAM_WE_N  (we_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n),
        .read_valid (read_valid),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce_n, we_n, oe_n, ub_n, lb_n;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic        exp_valid;
        logic [15:0] exp_dq;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs [NV];

    function automatic vec_t wr_v(input logic [17:0] a, input logic [15:0] d,
                                  input logic u, input logic l,
                                  input logic [15:0] r, input logic [15:0] w);
        vec_t v;
        v.ce_n = 0; v.we_n = 0; v.oe_n = 1; v.ub_n = u; v.lb_n = l;
        v.addr = a; v.wdata = d;
        v.exp_valid = 0; v.exp_dq = 16'h0000; v.exp_rd = r; v.exp_wr = w;
        return v;
    endfunction

    function automatic vec_t rd_v(input logic [17:0] a, input logic u,
                                  input logic ev, input logic [15:0] ed,
                                  input logic [15:0] r, input logic [15:0] w);
        vec_t v;
        v.ce_n = 0; v.we_n = 1; v.oe_n = 0; v.ub_n = u; v.lb_n = 0;
        v.addr = a; v.wdata = 16'h0000;
        v.exp_valid = ev; v.exp_dq = ed; v.exp_rd = r; v.exp_wr = w;
        return v;
    endfunction

    function automatic vec_t idle_v(input logic [15:0] r, input logic [15:0] w);
        vec_t v;
        v.ce_n = 1; v.we_n = 1; v.oe_n = 1; v.ub_n = 0; v.lb_n = 0;
        v.addr = '0; v.wdata = 16'h0000;
        v.exp_valid = 0; v.exp_dq = 16'h0000; v.exp_rd = r; v.exp_wr = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ce_n = v.ce_n; we_n = v.we_n; oe_n = v.oe_n;
        ub_n = v.ub_n; lb_n = v.lb_n; sram_addr = v.addr;
        dq_drv = v.wdata;
        dq_drv_en = ~v.we_n & ~v.ce_n;
    endtask

    task automatic set_read(input logic [17:0] a);
        ce_n = 0; we_n = 1; oe_n = 0; ub_n = 0; lb_n = 0;
        sram_addr = a; dq_drv_en = 0;
    endtask

    task automatic set_idle();
        ce_n = 1; we_n = 1; oe_n = 1; ub_n = 0; lb_n = 0;
        sram_addr = '0; dq_drv_en = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        dq_drv = 16'h0000;
        set_idle();

        vecs[0]  = wr_v(18'h00010, 16'hBEEF, 0, 0, 0, 1);
        vecs[1]  = rd_v(18'h00010, 0, 0, 16'h0000, 0, 1);
        vecs[2]  = rd_v(18'h00010, 0, 0, 16'h0000, 0, 1);
        vecs[3]  = rd_v(18'h00010, 0, 1, 16'hBEEF, 1, 1);
        vecs[4]  = rd_v(18'h00010, 0, 1, 16'hBEEF, 1, 1);
        vecs[5]  = idle_v(1, 1);
        vecs[6]  = wr_v(18'h00020, 16'h1234, 0, 0, 1, 2);
        vecs[7]  = wr_v(18'h00020, 16'hAB00, 0, 1, 1, 3);
        vecs[8]  = rd_v(18'h00020, 0, 0, 16'h0000, 1, 3);
        vecs[9]  = rd_v(18'h00020, 0, 0, 16'h0000, 1, 3);
        vecs[10] = rd_v(18'h00020, 0, 1, 16'hAB34, 2, 3);
        vecs[11] = rd_v(18'h00020, 1, 1, 16'h0034, 2, 3);
        vecs[12] = idle_v(2, 3);
        vecs[13] = wr_v(18'h01005, 16'h5A5A, 0, 0, 2, 4);
        vecs[14] = rd_v(18'h00005, 0, 0, 16'h0000, 2, 4);
        vecs[15] = rd_v(18'h00005, 0, 0, 16'h0000, 2, 4);
        vecs[16] = rd_v(18'h00005, 0, 1, 16'h5A5A, 3, 4);
        vecs[17] = rd_v(18'h01005, 0, 1, 16'h5A5A, 3, 4);
        vecs[18] = idle_v(3, 4);
        vecs[19] = wr_v(18'h00FFF, 16'h1111, 0, 0, 3, 5);
        vecs[20] = wr_v(18'h01000, 16'h2222, 0, 0, 3, 6);
        vecs[21] = rd_v(18'h00FFF, 0, 0, 16'h0000, 3, 6);
        vecs[22] = rd_v(18'h00FFF, 0, 0, 16'h0000, 3, 6);
        vecs[23] = rd_v(18'h00FFF, 0, 1, 16'h1111, 4, 6);
        vecs[24] = rd_v(18'h00000, 0, 0, 16'h0000, 4, 6);
        vecs[25] = rd_v(18'h00000, 0, 0, 16'h0000, 4, 6);
        vecs[26] = rd_v(18'h00000, 0, 1, 16'h2222, 5, 6);
        vecs[27] = wr_v(18'h00011, 16'hC011, 0, 0, 5, 7);
        vecs[28] = rd_v(18'h00010, 0, 0, 16'h0000, 5, 7);
        vecs[29] = rd_v(18'h00011, 0, 0, 16'h0000, 5, 7);
        vecs[30] = rd_v(18'h00011, 0, 0, 16'h0000, 5, 7);
        vecs[31] = rd_v(18'h00011, 0, 1, 16'hC011, 6, 7);
        vecs[32] = idle_v(6, 7);
        vecs[33] = wr_v(18'h00030, 16'h7777, 0, 0, 6, 8);
        vecs[34] = rd_v(18'h00030, 0, 0, 16'h0000, 6, 8);
        vecs[35] = rd_v(18'h00030, 0, 0, 16'h0000, 6, 8);
        vecs[36] = rd_v(18'h00030, 0, 1, 16'h7777, 7, 8);

        // Reset state
        #12;
        chk("reset_valid", {15'd0, read_valid}, 16'h0000);
        chk("reset_rd_count", rd_count, 16'h0000);
        chk("reset_wr_count", wr_count, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d_valid", i), {15'd0, read_valid}, {15'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid)
                chk($sformatf("v%0d_dq", i), sram_dq, vecs[i].exp_dq);
            chk($sformatf("v%0d_rd_count", i), rd_count, vecs[i].exp_rd);
            chk($sformatf("v%0d_wr_count", i), wr_count, vecs[i].exp_wr);
        end

        // Combinational release on OE_N while driving 0x30.
        oe_n = 1'b1;
        #1;
        chk("oe_release_valid", {15'd0, read_valid}, 16'h0000);
        oe_n = 1'b0;
        #1;
        chk("oe_restore_valid", {15'd0, read_valid}, 16'h0001);
        chk("oe_restore_dq", sram_dq, 16'h7777);

        // WE_N dropped in READ_DRIVE: immediate release, write commits.
        we_n = 1'b0; dq_drv = 16'h9999; dq_drv_en = 1'b1;
        #1;
        chk("we_release_valid", {15'd0, read_valid}, 16'h0000);
        chk("we_bus_dq", sram_dq, 16'h9999);
        tick();
        chk("we_commit_wr_count", wr_count, 16'd9);
        set_read(18'h00030);
        tick();
        chk("we_reread_wait1", {15'd0, read_valid}, 16'h0000);
        tick();
        chk("we_reread_wait2", {15'd0, read_valid}, 16'h0000);
        tick();
        chk("we_reread_valid", {15'd0, read_valid}, 16'h0001);
        chk("we_reread_dq", sram_dq, 16'h9999);
        chk("we_reread_rd_count", rd_count, 16'd8);

        // Reset during READ_WAIT.
        set_idle();
        tick();
        set_read(18'h00010);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_valid", {15'd0, read_valid}, 16'h0000);
        chk("rst_wait_rd_count", rd_count, 16'h0000);
        chk("rst_wait_wr_count", wr_count, 16'h0000);
        tick();
        chk("rst_wait_hold_valid", {15'd0, read_valid}, 16'h0000);
        set_idle();
        @(negedge clk);
        rst = 1'b0;

        // Reset during READ_DRIVE.
        set_read(18'h00010);
        tick(); tick(); tick();
        chk("pre_rst_drive_valid", {15'd0, read_valid}, 16'h0001);
        chk("pre_rst_drive_dq", sram_dq, 16'hBEEF);
        #2 rst = 1'b1;
        #1;
        chk("rst_drive_valid", {15'd0, read_valid}, 16'h0000);
        chk("rst_drive_rd_count", rd_count, 16'h0000);
        set_idle();
        @(negedge clk);
        rst = 1'b0;

        // Full latency after reset; memory preserved.
        set_read(18'h00010);
        tick();
        chk("post_rst_wait1", {15'd0, read_valid}, 16'h0000);
        tick();
        chk("post_rst_wait2", {15'd0, read_valid}, 16'h0000);
        tick();
        chk("post_rst_valid", {15'd0, read_valid}, 16'h0001);
        chk("post_rst_dq", sram_dq, 16'hBEEF);
        chk("post_rst_rd_count", rd_count, 16'd1);
        chk("post_rst_wr_count", wr_count, 16'd0);

        set_idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
